// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// Purpose
//   32 x 32-bit register file with an integrated RAW scoreboard for a simple
//   in-order pipeline. Each architectural register carries a 2-bit pending
//   write counter (0..3). Decode is told to stall when a source it reads
//   still has a pending write, or when the destination counter it would
//   bump is already saturated. Register 0 is hard-wired to zero and is
//   never busy.
//
// Configuration
//   REGFILE_BYPASS_EN  When defined, a commit in the current cycle is
//                      forwarded straight to rd1/rd2, and the source busy
//                      term is released in that same cycle if this commit
//                      is the last pending write. When undefined, reads
//                      return stored contents only and a source stays
//                      stalled until the cycle after its final commit.
//
// Ports
//   clk          in   1   sole clock, rising edge
//   reset        in   1   asynchronous, active-low reset
//   ra1, ra2     in   5   decode source register addresses
//   use1, use2   in   1   decode instruction actually reads ra1 / ra2
//   rd1, rd2     out  32  source operand data (combinational read)
//   issue_valid  in   1   decode instruction issues with a pending write
//   issue_dst    in   5   destination of the issuing instruction
//   reg_write    in   1   writeback commit strobe
//   write_reg    in   5   writeback destination
//   resultW      in   32  writeback data
//   stall        out  1   decode must hold; current instruction not issued
//   busy         out  32  bit i set when register i has a pending write
// ---------------------------------------------------------------------------

package regfile_scoreboard_pkg;

   typedef logic [4:0]  creg_addr_t;
   typedef logic [31:0] u32;
   typedef logic [1:0]  pend_cnt_t;

   localparam int unsigned NUM_REGS = 32;
   localparam pend_cnt_t   CNT_MAX  = 2'd3;
   localparam pend_cnt_t   CNT_ONE  = 2'd1;

endpackage : regfile_scoreboard_pkg

module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  creg_addr_t ra1,
   input  creg_addr_t ra2,
   input  logic       use1,
   input  logic       use2,
   output u32         rd1,
   output u32         rd2,
   input  logic       issue_valid,
   input  creg_addr_t issue_dst,
   input  logic       reg_write,
   input  creg_addr_t write_reg,
   input  u32         resultW,
   output logic       stall,
   output logic [NUM_REGS-1:0] busy
);

   // ------------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------------
   u32        regs    [NUM_REGS];
   pend_cnt_t cnt     [NUM_REGS];
   pend_cnt_t cnt_nxt [NUM_REGS];

   // Commit and issue qualifiers. Writes to register 0 are dropped here so
   // that neither the data array nor the counters ever see them.
   logic                wr_en;
   logic                inc_en;
   logic [NUM_REGS-1:0] inc_sel;
   logic [NUM_REGS-1:0] dec_sel;

   // Per-source stall contributions and the saturation term.
   logic hold1;
   logic hold2;
   logic sat_hold;

   assign wr_en = reg_write && (write_reg != '0);

   // ------------------------------------------------------------------------
   // Register file data array
   // ------------------------------------------------------------------------
   // NOTE: the data array is reset on purpose: after reset every register
   // must read zero, so this cannot be mapped onto a reset-less RAM macro.
   // Register 0 is never written (wr_en excludes it) and therefore stays 0.
   // NOTE: sequential state is always updated with non-blocking assignments
   // so every flop samples the pre-edge values of its inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[write_reg] <= resultW;
      end
   end

   // ------------------------------------------------------------------------
   // Pending-write counters
   // ------------------------------------------------------------------------
   // One-hot selects for the issue increment and the commit decrement. The
   // decrement select is raised for any commit to a non-zero register, even
   // when its counter is already 0, so that a same-register issue+commit
   // pair is always treated as "no change".
   always_comb begin
      inc_sel = '0;
      dec_sel = '0;
      if (inc_en) begin
         inc_sel[issue_dst] = 1'b1;
      end
      if (wr_en) begin
         dec_sel[write_reg] = 1'b1;
      end
   end

   // NOTE: every signal assigned in an always_comb gets a default at the
   // top of the block; a path that leaves one unassigned infers a latch.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_nxt[i] = cnt[i];
         if (i == 0) begin
            cnt_nxt[i] = '0;
         end else if (inc_sel[i] && !dec_sel[i]) begin
            // Cannot wrap: an issue to a saturated counter raises stall,
            // which in turn blocks inc_en.
            cnt_nxt[i] = cnt[i] + CNT_ONE;
         end else if (dec_sel[i] && !inc_sel[i] && (cnt[i] != '0)) begin
            // A commit with nothing pending is ignored rather than
            // underflowing.
            cnt_nxt[i] = cnt[i] - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

   always_comb begin
      busy = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         busy[i] = (cnt[i] != '0);
      end
   end

   // ------------------------------------------------------------------------
   // Read ports and source hazard terms
   // ------------------------------------------------------------------------
   // busy[0] is constant 0, so a source address of 0 can never stall.
`ifdef REGFILE_BYPASS_EN
   logic byp1_hit;
   logic byp2_hit;

   // Forwarding is gated by reset so the read ports show zero while the
   // block is held in reset, regardless of a commit strobe on the inputs.
   assign byp1_hit = reset && wr_en && (write_reg == ra1);
   assign byp2_hit = reset && wr_en && (write_reg == ra2);

   assign rd1 = byp1_hit ? resultW : regs[ra1];
   assign rd2 = byp2_hit ? resultW : regs[ra2];

   // The busy term is dropped only when the commit in flight is the last
   // outstanding write; with more writes pending the forwarded value is
   // not the one this instruction depends on.
   assign hold1 = use1 && busy[ra1] && !(byp1_hit && (cnt[ra1] == CNT_ONE));
   assign hold2 = use2 && busy[ra2] && !(byp2_hit && (cnt[ra2] == CNT_ONE));
`else
   assign rd1 = regs[ra1];
   assign rd2 = regs[ra2];

   assign hold1 = use1 && busy[ra1];
   assign hold2 = use2 && busy[ra2];
`endif

   // ------------------------------------------------------------------------
   // Stall and issue
   // ------------------------------------------------------------------------
   // issue_valid enters stall only through the saturation term; cnt[0] is
   // always 0, so issuing to register 0 never saturates.
   assign sat_hold = issue_valid && (cnt[issue_dst] == CNT_MAX);
   assign stall    = hold1 || hold2 || sat_hold;

   // An instruction held by stall does not issue and leaves no pending
   // write behind.
   assign inc_en = issue_valid && !stall && (issue_dst != '0);

endmodule : regfile_scoreboard

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports ra1, ra2  in  5 (creg_addr_t)  decode-stage source register addresses.
REQ-004 SHALL have ports use1, use2  in  1  decode instruction actually reads ra1 / ra2.
REQ-005 SHALL have ports rd1, rd2  out  32 (u32)  source operand data.
REQ-006 SHALL have ports issue_valid  in  1  and issue_dst  in  5  decode instruction issues with a pending write to issue_dst.
REQ-007 SHALL have ports reg_write  in  1, write_reg  in  5, resultW  in  32 (u32)  commit write from the writeback stage.
REQ-008 SHALL have port stall  out  1  decode must hold; the current instruction is not issued.
REQ-009 SHALL have port busy  out  32  bit i set when register i has at least one pending write.

Function
REQ-010 SHALL hold 32 x 32-bit registers; register 0 SHALL always read 0 and SHALL ignore writes.
REQ-011 SHALL write resultW into reg[write_reg] at the rising edge when reg_write=1 and write_reg!=0.
REQ-012 SHALL drive rd1/rd2 combinationally from reg[ra1]/reg[ra2], giving zero-cycle read latency.
REQ-013 SHALL keep a 2-bit pending counter per register (0..3); busy[i] = (cnt[i]!=0); cnt[0] and busy[0] SHALL be fixed at 0.
REQ-014 SHALL increment cnt[issue_dst] at the edge when issue_valid=1, stall=0 and issue_dst!=0.
REQ-015 SHALL decrement cnt[write_reg] at the edge when reg_write=1 and write_reg!=0; a decrement at cnt=0 SHALL be ignored (no underflow).
REQ-016 SHALL leave the counter unchanged when an increment and a decrement target the same register in the same cycle.
REQ-017 SHALL assert stall when (use1 and busy[ra1]) or (use2 and busy[ra2]) or (issue_valid and cnt[issue_dst]=3), subject to REQ-022.
REQ-018 SHALL ignore issue_valid while stall=1; stall SHALL NOT depend on issue_valid except through the saturation term.
REQ-019 SHALL treat ra=0 as never busy and never stalling.

Reset
REQ-020 SHALL, while reset=0, asynchronously clear all registers, all counters and busy to 0; stall SHALL be 0 and rd1/rd2 SHALL read 0.
REQ-021 SHALL discard any writes and issues in flight when reset is asserted mid-operation; the first edge after deassertion SHALL process inputs normally.

Configuration
REQ-022 With REGFILE_BYPASS_EN defined: rd1/rd2 SHALL return resultW when reg_write=1, write_reg=ra and ra!=0; the busy term for that source in stall SHALL be suppressed when cnt[ra]=1 and that write commits this cycle.
REQ-023 Without REGFILE_BYPASS_EN: rd1/rd2 SHALL return only stored contents; a source stays stalled until the cycle after its final write commits.

Verification
REQ-024 Reset: drive reset=0 mid-stream, then release; ra1=5 -> rd1=0, busy=0, stall=0.
REQ-025 Write/read: reg_write=1, write_reg=7, resultW=0xDEADBEEF; next cycle ra1=7 -> rd1=0xDEADBEEF; write to reg 0 with 0x1234 -> rd of reg 0 = 0.
REQ-026 RAW hazard: issue dst=3; next cycle use1=1, ra1=3 -> stall=1 until writeback of reg 3 with 0x55; the bypass build releases in the commit cycle with rd1=0x55; the non-bypass build releases one cycle later.
REQ-027 Simultaneous issue and commit on reg 4 with cnt=1 -> cnt stays 1 and busy[4]=1.
REQ-028 Saturation: three issues to reg 9 -> cnt=3; a fourth issue to reg 9 -> stall=1 and cnt stays 3; a spurious commit to reg 10 with cnt=0 -> cnt stays 0.
